// File: rtl/stream_downsizer.sv
// Reader-side width converter: serialises each wide valid/ready beat into narrow
// words, LSB word first, with partial-beat word counts and packet-end propagation.
module stream_downsizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  us_valid,
  input  logic [IN_WIDTH-1:0]                   us_data,
  input  logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] us_words,
  input  logic                                  us_last,
  output logic                                  us_ready,
  output logic                                  ds_valid,
  output logic [OUT_WIDTH-1:0]                  ds_data,
  output logic                                  ds_last,
  input  logic                                  ds_ready
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
    $error("stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 dlast_q, dlast_d;

  logic final_word;
  logic us_hs;
  logic ds_hs;

  assign final_word = (idx_q == cnt_q);
  // Accept a new beat either when empty or as the final word leaves, so beats chain without a bubble.
  assign us_ready   = rst_n && ((state_q == EMPTY) || (ds_ready && final_word));
  assign us_hs      = us_valid && us_ready;
  assign ds_hs      = (state_q == BUSY) && ds_ready;

  assign ds_valid = (state_q == BUSY);
  assign ds_data  = shift_q[OUT_WIDTH-1:0];
  assign ds_last  = dlast_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dlast_d = dlast_q;
    if (us_hs) begin
      state_d = BUSY;
      shift_d = us_data;
      idx_d   = '0;
      cnt_d   = us_words;
      last_d  = us_last;
      dlast_d = us_last && (us_words == '0);
    end else if (ds_hs) begin
      if (final_word) begin
        state_d = EMPTY;
        dlast_d = 1'b0;
      end else begin
        shift_d = shift_q >> OUT_WIDTH;
        idx_d   = idx_q + CNT_W'(1);
        dlast_d = last_q && ((idx_q + CNT_W'(1)) == cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      dlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dlast_q <= dlast_d;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer: reset, full/partial/back-to-back beats,
// random backpressure against a word queue, and reset in the middle of a beat.
module tb_stream_downsizer;

  localparam int IW = 512;
  localparam int OW = 32;
  localparam int R  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          us_valid;
  logic [IW-1:0] us_data;
  logic [CW-1:0] us_words;
  logic          us_last;
  logic          us_ready;
  logic          ds_valid;
  logic [OW-1:0] ds_data;
  logic          ds_last;
  logic          ds_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .us_valid(us_valid), .us_data(us_data), .us_words(us_words), .us_last(us_last),
    .us_ready(us_ready),
    .ds_valid(ds_valid), .ds_data(ds_data), .ds_last(ds_last), .ds_ready(ds_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk_beat(input logic [31:0] base, input int nw,
                                            input logic [31:0] fill);
    logic [IW-1:0] b;
    b = '0;
    for (int i = 0; i < R; i++) b[i*OW +: OW] = (i <= nw) ? base + 32'(i) : fill;
    return b;
  endfunction

  task automatic drive_beat(input logic [IW-1:0] d, input int nw, input logic l);
    us_valid = 1'b1;
    us_data  = d;
    us_words = CW'(nw);
    us_last  = l;
  endtask

  logic [32:0]   expq[$];
  logic [32:0]   e;
  logic          pend, prev_stall, prev_last;
  logic [OW-1:0] prev_data;
  logic [IW-1:0] bd;
  int            nw, sent, acc, cyc, n_dlast, n_ulast, nacc;

  initial begin
    rst_n = 1'b0; us_valid = 1'b0; us_data = '0; us_words = '0; us_last = 1'b0; ds_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_ds_valid", ds_valid, 0);
    check("rst_ds_data", ds_data, 0);
    check("rst_ds_last", ds_last, 0);
    check("rst_us_ready", us_ready, 1);
    tick;

    // Single full beat
    drive_beat(mk_beat(32'h1000, 15, 32'h0), 15, 1'b1);
    ds_ready = 1'b1;
    #1 check("full_us_ready", us_ready, 1);
    tick;
    us_valid = 1'b0;
    for (int i = 0; i < R; i++) begin
      check("full_valid", ds_valid, 1);
      check("full_data", ds_data, 32'h1000 + 32'(i));
      check("full_last", ds_last, (i == R - 1));
      tick;
    end
    check("full_idle", ds_valid, 0);

    // Four back-to-back full beats
    nacc = 0;
    for (int t = 0; t <= 4 * R; t++) begin
      if (nacc < 4) drive_beat(mk_beat(32'h2000 + 32'(nacc * R), 15, 32'h0), 15, (nacc == 3));
      else us_valid = 1'b0;
      #1;
      check("b2b_us_ready", us_ready, (t % R == 0));
      if (t >= 1) begin
        check("b2b_valid", ds_valid, 1);
        check("b2b_data", ds_data, 32'h2000 + 32'(t - 1));
        check("b2b_last", ds_last, (t == 4 * R));
      end
      if (us_valid && us_ready) nacc++;
      tick;
    end
    check("b2b_idle", ds_valid, 0);

    // Partial beat, stall on its final word, then a beat loaded in the same cycle as that word leaves
    drive_beat(mk_beat(32'h3000, 2, 32'hDEAD), 2, 1'b1);
    #1 check("part_us_ready", us_ready, 1);
    tick;
    us_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("part_data", ds_data, 32'h3000 + 32'(i));
      check("part_last", ds_last, 0);
      check("part_us_ready_mid", us_ready, 0);
      tick;
    end
    ds_ready = 1'b0;
    drive_beat(mk_beat(32'h4000, 0, 32'hDEAD), 0, 1'b1);
    #1;
    check("stall_us_ready", us_ready, 0);
    check("part_data3", ds_data, 32'h3002);
    check("part_last3", ds_last, 1);
    tick;
    check("stall_hold_data", ds_data, 32'h3002);
    check("stall_hold_valid", ds_valid, 1);
    ds_ready = 1'b1;
    #1 check("final_us_ready", us_ready, 1);
    tick;
    us_valid = 1'b0;
    check("chain_valid", ds_valid, 1);
    check("chain_data", ds_data, 32'h4000);
    check("chain_last", ds_last, 1);
    tick;
    check("chain_idle", ds_valid, 0);
    check("chain_us_ready", us_ready, 1);

    // Single word, no packet end
    drive_beat(mk_beat(32'h4100, 0, 32'hDEAD), 0, 1'b0);
    tick;
    us_valid = 1'b0;
    check("one_data", ds_data, 32'h4100);
    check("one_last", ds_last, 0);
    tick;
    check("one_idle", ds_valid, 0);

    // Random backpressure
    pend = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    sent = 0; acc = 0; cyc = 0; n_dlast = 0; n_ulast = 0;
    while ((acc < 100 || expq.size() != 0 || ds_valid) && cyc < 20000) begin
      if (!pend) us_valid = 1'b0;
      ds_ready = ($urandom_range(0, 9) < 3);
      if (!pend && sent < 100 && $urandom_range(0, 3) != 0) begin
        nw = ($urandom_range(0, 1) != 0) ? 15 : int'($urandom_range(0, 15));
        for (int i = 0; i < R; i++) bd[i*OW +: OW] = (i <= nw) ? $urandom : (32'hDEAD0000 | 32'(i));
        drive_beat(bd, nw, 1'($urandom_range(0, 1)));
        pend = 1'b1;
        sent++;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold_valid", ds_valid, 1);
        check("bp_hold_data", ds_data, prev_data);
        check("bp_hold_last", ds_last, prev_last);
      end
      if (ds_valid && ds_ready) begin
        if (expq.size() == 0) check("bp_extra_word", ds_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = expq.pop_front();
          check("bp_data", ds_data, e[31:0]);
          check("bp_last", ds_last, e[32]);
        end
        if (ds_last) n_dlast++;
      end
      if (us_valid && us_ready) begin
        for (int i = 0; i <= int'(us_words); i++)
          expq.push_back({us_last && (i == int'(us_words)), us_data[i*OW +: OW]});
        if (us_last) n_ulast++;
        acc++;
        pend = 1'b0;
      end
      prev_stall = ds_valid && !ds_ready;
      prev_data  = ds_data;
      prev_last  = ds_last;
      tick;
      cyc++;
    end
    us_valid = 1'b0;
    check("bp_timeout", (cyc < 20000), 1);
    check("bp_accepted", acc, 100);
    check("bp_last_count", n_dlast, n_ulast);

    // Reset in the middle of a beat, applied between clock edges
    ds_ready = 1'b1;
    drive_beat(mk_beat(32'h5000, 15, 32'h0), 15, 1'b1);
    tick;
    us_valid = 1'b0;
    repeat (6) tick;
    check("mid_data_before", ds_data, 32'h5006);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", ds_valid, 0);
    check("async_data", ds_data, 0);
    check("async_last", ds_last, 0);
    tick;
    #2 rst_n = 1'b1;
    tick;
    check("post_rst_idle", ds_valid, 0);
    drive_beat(mk_beat(32'hA0, 15, 32'h0), 15, 1'b1);
    tick;
    us_valid = 1'b0;
    for (int i = 0; i < R; i++) begin
      check("post_rst_valid", ds_valid, 1);
      check("post_rst_data", ds_data, 32'hA0 + 32'(i));
      check("post_rst_last", ds_last, (i == R - 1));
      tick;
    end
    check("post_rst_idle_end", ds_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
